// File: rtl/keypad_scan_if.sv
// Keypad pin and key-report bundle for keypad_scan.
// The master side is the scanner: it drives the row strobes and the key report,
// and receives the column returns from the keypad matrix.
interface keypad_scan_if;
    logic [3:0] col;        // active-low column returns, external pull-ups
    logic [3:0] row;        // one-hot active-low row drive
    logic [3:0] key_code;   // last accepted key, row_index*4 + col_index
    logic       key_valid;  // one-cycle pulse when key_code is updated
    logic       key_down;   // high while a debounced key is held

    modport master (input col, output row, key_code, key_valid, key_down);
    modport slave  (output col, input row, key_code, key_valid, key_down);
endinterface

// File: rtl/keypad_scan.sv
// Scanned 4x4 matrix keypad front end.
// Strobes one row at a time, samples the synchronized columns at the end of each
// row slot, reduces each 4-row frame to a single key (or none) and debounces
// presses and releases over whole frames. One key_valid pulse per accepted press.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN adds held-key auto-repeat pulses
// after REPEAT_DELAY frames, then every REPEAT_RATE frames.
module keypad_scan #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic          clk,
    input  logic          reset,
    keypad_scan_if.master kp
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_CHK,
        S_HELD,
        S_REL_CHK
    } state_e;

    localparam int            PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [3:0]    DEB       = 4'(DEBOUNCE);
    localparam bit            DEB_ONE   = (DEBOUNCE == 1);

    if (SCAN_DIV < 4 || DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
    begin : g_bad_param
        $error("keypad_scan: parameter out of legal range");
    end

    logic [PW-1:0] presc_q;
    logic [1:0]    ri_q;
    logic          tick;
    logic          frame_end;
    logic [3:0]    col_meta_q, col_sync_q;
    logic          row_hit;
    logic [1:0]    row_col;
    logic          frame_hit_q;
    logic [3:0]    frame_key_q;
    logic          res_hit;
    logic [3:0]    res_key;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_down_q, key_down_d;
    logic          accept;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int            REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int            RW      = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] REP_DLY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_RT  = RW'(REPEAT_RATE);
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_first_q, rep_first_d;
`endif

    assign tick      = (presc_q == PRESC_MAX);
    assign frame_end = tick && (ri_q == 2'd3);

    assign kp.row       = ~(4'b0001 << ri_q);
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;

    // Row slot timing: prescaler wraps every SCAN_DIV cycles and steps the row index.
    // NOTE: clocked blocks use non-blocking (<=) so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            ri_q    <= 2'd0;
        end else if (tick) begin
            presc_q <= '0;
            ri_q    <= ri_q + 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous column inputs; idles at "no key".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= kp.col;
            col_sync_q <= col_meta_q;
        end
    end

    // Lowest-numbered low column of the row currently being sampled.
    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        row_hit = ~&col_sync_q;
        row_col = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_sync_q[c]) row_col = 2'(c);
        end
    end

    // Frame result so far including this slot; an earlier key in scan order wins.
    assign res_hit = frame_hit_q | row_hit;
    assign res_key = frame_hit_q ? frame_key_q : {ri_q, row_col};

    // Accumulate the first key seen in the frame; cleared at each frame end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_hit_q <= 1'b0;
            frame_key_q <= 4'd0;
        end else if (frame_end) begin
            frame_hit_q <= 1'b0;
            frame_key_q <= 4'd0;
        end else if (tick) begin
            frame_hit_q <= res_hit;
            frame_key_q <= res_key;
        end
    end

    // Debounce FSM next state and outputs, evaluated once per frame end.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        accept      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
`endif
        if (frame_end) begin
            case (state_q)
                S_IDLE: begin
                    if (res_hit) begin
                        cand_d = res_key;
                        cnt_d  = 4'd1;
                        if (DEB_ONE) accept = 1'b1;
                        else         state_d = S_PRESS_CHK;
                    end
                end
                S_PRESS_CHK: begin
                    if (!res_hit) begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end else if (res_key == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DEB) accept = 1'b1;
                    end else begin
                        cand_d = res_key;
                        cnt_d  = 4'd1;
                    end
                end
                S_HELD: begin
                    if (!res_hit) begin
                        if (DEB_ONE) begin
                            key_down_d = 1'b0;
                            state_d    = S_IDLE;
                            cnt_d      = 4'd0;
                        end else begin
                            state_d = S_REL_CHK;
                            cnt_d   = 4'd1;
                        end
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else begin
                        if (rep_cnt_q + 1'b1 == (rep_first_q ? REP_DLY : REP_RT)) begin
                            key_valid_d = 1'b1;
                            rep_cnt_d   = '0;
                            rep_first_d = 1'b0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 1'b1;
                        end
                    end
`endif
                end
                S_REL_CHK: begin
                    if (res_hit) begin
                        state_d = S_HELD;
                        cnt_d   = 4'd0;
                    end else if (cnt_q + 4'd1 == DEB) begin
                        key_down_d = 1'b0;
                        state_d    = S_IDLE;
                        cnt_d      = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (accept) begin
            key_code_d  = cand_d;
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
            state_d     = S_HELD;
            cnt_d       = 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
`endif
        end
    end

    // Debounce FSM state and registered key report.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=8, DEBOUNCE=3 (32-cycle frames).
// A keypad matrix model pulls a column low while its row is strobed and the
// corresponding key is pressed. Key changes are applied at frame starts.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] keys;
    int          checks    = 0;
    int          failures  = 0;
    int          valid_cnt = 0;

    keypad_scan_if kp ();

    keypad_scan #(
        .SCAN_DIV    (8),
        .DEBOUNCE    (3),
        .REPEAT_DELAY(4),
        .REPEAT_RATE (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .kp   (kp.master)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key shorts its column to the driven (low) row.
    always_comb begin
        kp.col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!kp.row[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4+c]) kp.col[c] = 1'b0;
                end
            end
        end
    end

    always @(posedge kp.key_valid) valid_cnt++;

    // Advance to the first negedge of the next frame (row 3 seen, then row 0).
    task automatic wait_frame();
        int n;
        n = 0;
        while (kp.row !== 4'b0111 && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) begin $display("FAIL frame_wait_row3: row=%b never reached 0111", kp.row); failures++; end
        checks++;
        n = 0;
        while (kp.row !== 4'b1110 && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) begin $display("FAIL frame_wait_row0: row=%b never reached 1110", kp.row); failures++; end
        checks++;
    endtask

    task automatic wait_frames(input int n);
        repeat (n) wait_frame();
    endtask

    task automatic test_reset();
        logic [3:0] exp_row;
        bit         dirty;
        keys  = 16'h0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        if (kp.row !== 4'b1110) begin $display("FAIL rst_row: got %b want 1110", kp.row); failures++; end
        checks++;
        if (kp.key_code !== 4'd0) begin $display("FAIL rst_code: got %0d want 0", kp.key_code); failures++; end
        checks++;
        if (kp.key_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", kp.key_valid); failures++; end
        checks++;
        if (kp.key_down !== 1'b0) begin $display("FAIL rst_down: got %b want 0", kp.key_down); failures++; end
        checks++;
        reset = 1'b1;
        dirty = 1'b0;
        for (int k = 0; k < 32; k++) begin
            exp_row = ~(4'b0001 << (k / 8));
            if (kp.row !== exp_row) begin $display("FAIL scan_row[%0d]: got %b want %b", k, kp.row, exp_row); failures++; end
            checks++;
            if (kp.key_valid !== 1'b0 || kp.key_down !== 1'b0 || kp.key_code !== 4'd0) dirty = 1'b1;
            @(negedge clk);
        end
        wait_frame();
        if (dirty || valid_cnt != 0) begin
            $display("FAIL idle_outputs: dirty=%b pulses=%0d want 0/0", dirty, valid_cnt); failures++;
        end
        checks++;
    endtask

    task automatic test_hold_release();
        keys[9] = 1'b1;
        wait_frames(2);
        if (valid_cnt != 0 || kp.key_down !== 1'b0) begin
            $display("FAIL hold_early: pulses=%0d down=%b want 0/0", valid_cnt, kp.key_down); failures++;
        end
        checks++;
        wait_frame();
        if (kp.key_valid !== 1'b1) begin $display("FAIL hold_valid: got %b want 1", kp.key_valid); failures++; end
        checks++;
        if (kp.key_code !== 4'd9) begin $display("FAIL hold_code: got %0d want 9", kp.key_code); failures++; end
        checks++;
        if (kp.key_down !== 1'b1) begin $display("FAIL hold_down: got %b want 1", kp.key_down); failures++; end
        checks++;
        @(negedge clk);
        if (kp.key_valid !== 1'b0) begin $display("FAIL hold_pulse_width: got %b want 0", kp.key_valid); failures++; end
        checks++;
        wait_frames(2);
        keys = 16'h0;
        if (valid_cnt != 1) begin $display("FAIL hold_one_pulse: got %0d want 1", valid_cnt); failures++; end
        checks++;
        wait_frames(2);
        if (kp.key_down !== 1'b1) begin $display("FAIL rel_early: down=%b want 1", kp.key_down); failures++; end
        checks++;
        wait_frame();
        if (kp.key_down !== 1'b0) begin $display("FAIL rel_down: got %b want 0", kp.key_down); failures++; end
        checks++;
        if (kp.key_code !== 4'd9 || valid_cnt != 1) begin
            $display("FAIL rel_code_hold: code=%0d pulses=%0d want 9/1", kp.key_code, valid_cnt); failures++;
        end
        checks++;
    endtask

    task automatic test_bounce();
        int base;
        base = valid_cnt;
        keys[5] = 1'b1; wait_frames(2);
        keys = 16'h0;   wait_frames(3);
        if (valid_cnt != base || kp.key_down !== 1'b0 || kp.key_code !== 4'd9) begin
            $display("FAIL glitch: pulses=%0d down=%b code=%0d want %0d/0/9", valid_cnt - base, kp.key_down, kp.key_code, 0);
            failures++;
        end
        checks++;
        keys[5] = 1'b1; wait_frames(2);
        keys = 16'h0;   wait_frame();
        keys[5] = 1'b1; wait_frames(2);
        if (valid_cnt != base) begin $display("FAIL bounce_early: pulses=%0d want 0", valid_cnt - base); failures++; end
        checks++;
        wait_frame();
        if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd5) begin
            $display("FAIL bounce_accept: valid=%b code=%0d want 1/5", kp.key_valid, kp.key_code); failures++;
        end
        checks++;
        keys = 16'h0;
        wait_frames(4);
        if (kp.key_down !== 1'b0 || valid_cnt != base + 1) begin
            $display("FAIL bounce_release: down=%b pulses=%0d want 0/1", kp.key_down, valid_cnt - base); failures++;
        end
        checks++;
    endtask

    task automatic test_two_keys();
        int base;
        base = valid_cnt;
        keys[3]  = 1'b1;
        keys[12] = 1'b1;
        wait_frames(3);
        if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd3) begin
            $display("FAIL two_priority: valid=%b code=%0d want 1/3", kp.key_valid, kp.key_code); failures++;
        end
        checks++;
        keys[3] = 1'b0;
        wait_frames(4);
        if (valid_cnt != base + 1 || kp.key_down !== 1'b1 || kp.key_code !== 4'd3) begin
            $display("FAIL two_switch: pulses=%0d down=%b code=%0d want 1/1/3", valid_cnt - base, kp.key_down, kp.key_code);
            failures++;
        end
        checks++;
        keys = 16'h0;
        wait_frames(4);
        if (kp.key_down !== 1'b0 || valid_cnt != base + 1) begin
            $display("FAIL two_release: down=%b pulses=%0d want 0/1", kp.key_down, valid_cnt - base); failures++;
        end
        checks++;
        keys[12] = 1'b1;
        wait_frames(3);
        if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd12) begin
            $display("FAIL two_repress: valid=%b code=%0d want 1/12", kp.key_valid, kp.key_code); failures++;
        end
        checks++;
        keys = 16'h0;
        wait_frames(4);
    endtask

    task automatic test_reset_mid();
        int base;
        keys[6] = 1'b1;
        wait_frames(2);
        repeat (5) @(negedge clk);
        base  = valid_cnt;
        reset = 1'b0;
        #1;
        if (kp.row !== 4'b1110 || kp.key_code !== 4'd0 || kp.key_valid !== 1'b0 || kp.key_down !== 1'b0) begin
            $display("FAIL mid_reset_outputs: row=%b code=%0d valid=%b down=%b want 1110/0/0/0",
                     kp.row, kp.key_code, kp.key_valid, kp.key_down);
            failures++;
        end
        checks++;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        wait_frames(2);
        if (valid_cnt != base || kp.key_down !== 1'b0) begin
            $display("FAIL mid_reset_early: pulses=%0d down=%b want 0/0", valid_cnt - base, kp.key_down); failures++;
        end
        checks++;
        wait_frame();
        if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd6 || kp.key_down !== 1'b1) begin
            $display("FAIL mid_reset_accept: valid=%b code=%0d down=%b want 1/6/1", kp.key_valid, kp.key_code, kp.key_down);
            failures++;
        end
        checks++;
        keys = 16'h0;
        wait_frames(4);
    endtask

    task automatic test_autorepeat();
        int base;
        int exp_pulses;
        bit exp_valid;
        base = valid_cnt;
        keys[15] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            wait_frame();
`ifdef KEYPAD_AUTOREPEAT_EN
            exp_valid = (i == 3 || i == 7 || i == 9 || i == 11);
`else
            exp_valid = (i == 3);
`endif
            if (kp.key_valid !== exp_valid) begin
                $display("FAIL repeat_valid[frame %0d]: got %b want %b", i, kp.key_valid, exp_valid); failures++;
            end
            checks++;
            if (exp_valid && kp.key_code !== 4'd15) begin
                $display("FAIL repeat_code[frame %0d]: got %0d want 15", i, kp.key_code); failures++;
            end
            if (exp_valid) checks++;
        end
        keys = 16'h0;
        wait_frames(4);
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_pulses = 4;
`else
        exp_pulses = 1;
`endif
        if (valid_cnt != base + exp_pulses || kp.key_down !== 1'b0) begin
            $display("FAIL repeat_total: pulses=%0d down=%b want %0d/0", valid_cnt - base, kp.key_down, exp_pulses);
            failures++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_hold_release();
        test_bounce();
        test_two_keys();
        test_reset_mid();
        test_autorepeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanned 4x4 matrix keypad input block, the input-side counterpart of the multiplexed 7-segment display driver. It drives keypad rows one at a time, samples the columns, debounces over whole scan frames, and reports one key code per debounced press. It sits between the board keypad pins and the clock-setting logic; its row strobes are time-multiplexed the same way the display digit selects are.

## Interface
- SCAN_DIV, 100000: clk cycles per row step; legal range >= 4.
- DEBOUNCE, 4: consecutive agreeing scan frames needed to accept a press or release; legal range 1..15.
- REPEAT_DELAY, 50: frames a key must be held before the first auto-repeat (used only with KEYPAD_AUTOREPEAT_EN).
- REPEAT_RATE, 10: frames between auto-repeats (used only with KEYPAD_AUTOREPEAT_EN).
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low.
- col  input  4  keypad columns, active-low, external pull-ups, asynchronous to clk.
- row  output  4  keypad row drive, one-hot active-low.
- key_code  output  4  last accepted key, code = row_index*4 + col_index.
- key_valid  output  1  one-cycle pulse when key_code is updated.
- key_down  output  1  level, high while a debounced key is held.

## Operation
- Prescaler counts 0..SCAN_DIV-1 and produces a one-cycle tick at SCAN_DIV-1, then wraps to 0.
- Row index ri counts 0..3 and advances on each tick, wrapping 3->0. row = ~(1<<ri).
- col passes through a 2-flop synchronizer before use.
- On each tick, before ri advances, sample the synchronized col for the current row. The first low column in scan order (row 0 col 0 first, then increasing col, then increasing row) becomes the frame candidate. Later keys in the same frame are ignored.
- A frame ends on the tick that samples row 3. The frame result is either key K or NONE.
- Debounce FSM is evaluated once per frame end:
  - IDLE: result K -> PRESS_CHK with cand=K, cnt=1. If DEBOUNCE=1, accept immediately instead.
  - PRESS_CHK: result == cand -> cnt+1, and accept when cnt reaches DEBOUNCE. Different key -> restart with cand=new key, cnt=1. NONE -> IDLE.
  - Accept: key_code<=cand, key_valid pulse, key_down<=1, go to HELD.
  - HELD: any key -> stay; a change to a different key is not reported until release. NONE -> REL_CHK with cnt=1 (with DEBOUNCE=1, release immediately).
  - REL_CHK: NONE -> cnt+1; at DEBOUNCE, key_down<=0 and go to IDLE. Any key -> HELD, cnt cleared.
- key_code holds its value after release until the next accept.
- The reset assertion takes effect immediately regardless of state. No key_valid pulse is generated by reset or its release.

## Timing
- Reset values:
  - row=4'b1110
  - key_code=0
  - key_valid=0
  - key_down=0
  - prescaler=0, ri=0, FSM=IDLE, cnt=0, cand=0
- Each row is driven for exactly SCAN_DIV cycles before it is sampled. One frame lasts 4*SCAN_DIV cycles.
- Column input to sample path: 2 clk synchronizer delay. A level must be stable at least 2 cycles before a tick to count.
- Accept latency: key_valid rises 1 clk after the frame-end tick of the DEBOUNCE-th agreeing frame and stays high for exactly 1 clk. key_code changes on that same edge.
- key_down rises with key_valid. It falls 1 clk after the frame-end tick of the DEBOUNCE-th NONE frame.
- Minimum press-to-report time is DEBOUNCE frames, plus the partial frame in progress.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - HELD keeps a frame counter that is cleared on accept.
  - At REPEAT_DELAY frames it emits a key_valid pulse with unchanged key_code, then emits another every REPEAT_RATE frames while the key remains HELD.
  - REL_CHK freezes the counter; a return to HELD resumes it.
- Not defined: exactly one key_valid per press, and the repeat counters are not instantiated.

## Test plan
Bench parameters: SCAN_DIV=8, DEBOUNCE=3 (frame = 32 clk).
- Reset, no keys: row cycles 1110, 1101, 1011, 0111, each for 8 clk. key_valid, key_down and key_code stay 0.
- Hold row 2 col 1 (col=4'b1101 whenever row=1011) for 5 frames: exactly one key_valid, key_code=9, key_down=1. After release, key_down=0 three frames later.
- Bounce: key 5 present for 2 frames, absent for 1, present for 3: one key_valid, at the 3rd consecutive frame. A 2-frame glitch alone produces no pulse.
- Keys 3 and 12 pressed simultaneously: key_code=3. Releasing 3 while 12 is held: no new pulse until full release and re-press.
- Assert reset mid-PRESS_CHK after 2 good frames: outputs return to reset values immediately. After reset release, 3 fresh frames are needed before key_valid.
- With KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2, key 15 held for 12 frames: key_valid pulses at accept, then 4 frames later, then every 2 frames, all with key_code=15.
